// File: rtl/cmd_stream_pkg.sv
// Shared opcodes, FSM states and word geometry for the accelerator command stream.
package cmd_stream_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD_W = 4'h1;
  localparam logic [3:0] OP_LOAD_F = 4'h2;
  localparam logic [3:0] OP_RUN    = 4'h3;
  localparam logic [3:0] OP_END    = 4'hF;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_COUNT,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cmd_word_packer.sv
// Packs stream bytes big-endian into 32-bit words; flags the byte that completes a word.
module cmd_word_packer
  import cmd_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_complete,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // The completing byte is merged combinationally so the top can register the word on that edge.
  assign word_complete = byte_valid && (byte_cnt == LAST_BYTE);
  assign word          = {shift_q, byte_in};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], byte_in};
    end
  end

endmodule

// File: rtl/cmd_stream_decoder.sv
// Decodes framed command bytes into buffer write strobes plus run/end events.
module cmd_stream_decoder
  import cmd_stream_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sig,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              run_pulse,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              state;
  logic [7:0]          addr_hi;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [8:0]          words_left;
  logic [3:0]          opcode;
  logic [15:0]         full_addr;
  logic                data_byte;
  logic                word_complete;
  logic [31:0]         packed_word;

  assign opcode    = cmd_data[7:4];
  assign full_addr = {addr_hi, cmd_data};
  assign data_byte = start_sig && cmd_valid && (state == ST_DATA);

  cmd_word_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (!start_sig),
    .byte_valid    (data_byte),
    .byte_in       (cmd_data),
    .word_complete (word_complete),
    .word          (packed_word)
  );

  // Dropping start_sig abandons any frame; the packer is cleared alongside so no partial word survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR;
      addr_hi    <= 8'd0;
      addr_cnt   <= '0;
      words_left <= 9'd0;
      wr_en      <= 1'b0;
      wr_sel     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
      run_pulse  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      run_pulse <= 1'b0;
      if (!start_sig) begin
        state <= ST_HDR;
        done  <= 1'b0;
        err   <= 1'b0;
        busy  <= 1'b0;
      end else if (cmd_valid) begin
        case (state)
          ST_HDR: begin
            case (opcode)
              OP_NOP: ;
              OP_LOAD_W, OP_LOAD_F: begin
                state  <= ST_ADDR_HI;
                wr_sel <= (opcode == OP_LOAD_F);
                busy   <= 1'b1;
              end
              OP_RUN: run_pulse <= 1'b1;
              OP_END: begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
          ST_ADDR_HI: begin
            addr_hi <= cmd_data;
            state   <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_cnt <= ADDR_W'(full_addr);
            state    <= ST_COUNT;
          end
          // A zero count encodes the maximum frame of 256 words.
          ST_COUNT: begin
            words_left <= (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
            state      <= ST_DATA;
          end
          ST_DATA: begin
            if (word_complete) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_cnt;
              wr_data  <= packed_word;
              addr_cnt <= addr_cnt + ADDR_ONE;
              if (words_left == 9'd1) begin
                state <= ST_HDR;
                busy  <= 1'b0;
              end else begin
                words_left <= words_left - 9'd1;
              end
            end
          end
          ST_DONE: ;
          default: state <= ST_HDR;
        endcase
      end
    end
  end

endmodule
